// File: rtl/program_loader.sv
// Boot loader: frames a byte stream (length, little-endian words, XOR checksum) into the
// instruction memory and keeps the core in reset until a verified image is present.
module program_loader #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Handshake: a byte is consumed on a rising edge where byte_valid and byte_ready are
  // both 1; byte_ready depends only on the state register, never on byte_valid.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]      WORDS_B = 8'(WORDS);
  localparam logic [ADDR_W:0] WORDS_N = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

  state_t          state, state_nx;
  logic [23:0]     asm_q;
  logic [1:0]      lane;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic            accept;
  logic            word_end;
  logic            last_word;

  assign accept    = byte_valid & byte_ready;
  assign word_end  = accept && (state == S_DATA) && (lane == 2'd3);
  assign last_word = word_end && ((idx + ONE_N) == n_words);

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LEN;
      end
      S_LEN: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nx = (byte_data > WORDS_B) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (last_word) state_nx = S_CHK;
      end
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nx = (byte_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        if (start) state_nx = S_LEN;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nx = S_LEN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      asm_q        <= '0;
      lane         <= '0;
      idx          <= '0;
      n_words      <= '0;
      csum         <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      im_we <= 1'b0;
      if (im_we) words_loaded <= words_loaded + ONE_N;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            asm_q        <= '0;
            lane         <= '0;
            idx          <= '0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        S_LEN: begin
          if (accept) n_words <= (byte_data == 8'd0) ? WORDS_N : byte_data[ADDR_W:0];
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ byte_data;
            lane <= lane + 2'd1;
            // Fourth byte goes straight into the write register; the word never sits in asm_q.
            case (lane)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                im_we    <= 1'b1;
                im_addr  <= idx[ADDR_W-1:0];
                im_wdata <= {byte_data, asm_q};
                idx      <= idx + ONE_N;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
